// File: rtl/bloom_filter_table.sv
// bloom_filter_table: Bloom filter bit store, one bank per string length MIN_S..MAX_S,
//   HASH_CNT arrays of 2^HASH_WIDTH bits per bank. Lookup latency 1 cycle; writes commit
//   on the strobe edge. Writes are accepted only while ready=1 (IDLE); in CLEAR they are dropped.
// Ports:
//   clk_i, rst_n_i                  clock, async active-low reset
//   str_len, hash, hash_mask_val,   settings-side bit write (per-hash enable, value, strobe)
//   wr_data, wr_stb
//   full_clr_stb, ready,            whole-table clear request and status
//   full_clr_done
//   lookup_vld_i, lookup_len_i,     membership query in
//   lookup_hash_i
//   match_vld_o, match_o            registered query result out
module bloom_filter_table #(
  parameter int MIN_S      = 4,
  parameter int MAX_S      = 32,
  parameter int HASH_CNT   = 10,
  parameter int HASH_WIDTH = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic [$clog2(MAX_S):0]         str_len,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] hash,
  input  logic [HASH_CNT-1:0]            hash_mask_val,
  input  logic                           wr_data,
  input  logic                           wr_stb,
  input  logic                           full_clr_stb,
  output logic                           ready,
  output logic                           full_clr_done,
  input  logic                           lookup_vld_i,
  input  logic [$clog2(MAX_S):0]         lookup_len_i,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] lookup_hash_i,
  output logic                           match_vld_o,
  output logic                           match_o
);

  localparam int LW    = $clog2(MAX_S) + 1;
  localparam int NB    = MAX_S - MIN_S + 1;
  localparam int BW    = (NB > 1) ? $clog2(NB) : 1;
  localparam int DEPTH = 1 << HASH_WIDTH;
  localparam logic [LW-1:0] MIN_L = LW'(MIN_S);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_S);

  typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [HASH_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_match_vld, r_match;

  // Each word holds one bit per bank, so a clear of one address wipes every bank at once.
  logic [NB-1:0] r_mem [HASH_CNT][DEPTH];

  logic          w_wr_len_ok, w_lk_len_ok, w_wr_en, w_clr_en, w_hit;
  logic [BW-1:0] w_wr_bank, w_lk_bank;

  // Out-of-range lengths are steered to bank 0 but never allowed to write or hit.
  assign w_wr_len_ok = (str_len >= MIN_L) && (str_len <= MAX_L);
  assign w_lk_len_ok = (lookup_len_i >= MIN_L) && (lookup_len_i <= MAX_L);
  assign w_wr_bank   = w_wr_len_ok ? BW'(str_len - MIN_L) : '0;
  assign w_lk_bank   = w_lk_len_ok ? BW'(lookup_len_i - MIN_L) : '0;

  // A clear request in the same cycle wins over a write.
  assign w_wr_en  = wr_stb && r_ready && !full_clr_stb && w_wr_len_ok;
  assign w_clr_en = (r_state == ST_CLEAR);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_ready;
    w_done_nxt  = r_done;
    case (r_state)
      ST_CLEAR: begin
        if (full_clr_stb) begin
          w_cnt_nxt = '0;
        end else if (&r_cnt) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b1;
          w_done_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + HASH_WIDTH'(1);
        end
      end
      ST_IDLE: begin
        if (full_clr_stb) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
          w_ready_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_ready_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Storage has no reset; the automatic post-reset sweep zeroes it.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < HASH_CNT; i++) begin
      if (w_clr_en) begin
        r_mem[i][r_cnt] <= '0;
      end else if (w_wr_en && hash_mask_val[i]) begin
        r_mem[i][hash[i*HASH_WIDTH +: HASH_WIDTH]][w_wr_bank] <= wr_data;
      end
    end
  end

  // Combinational read of the current contents gives read-before-write on a same-cycle write.
  always_comb begin
    w_hit = w_lk_len_ok && (r_state == ST_IDLE);
    for (int i = 0; i < HASH_CNT; i++) begin
      w_hit = w_hit && r_mem[i][lookup_hash_i[i*HASH_WIDTH +: HASH_WIDTH]][w_lk_bank];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_match_vld <= 1'b0;
      r_match     <= 1'b0;
    end else begin
      r_match_vld <= lookup_vld_i;
      r_match     <= lookup_vld_i && w_hit;
    end
  end

  assign ready         = r_ready;
  assign full_clr_done = r_done;
  assign match_vld_o   = r_match_vld;
  assign match_o       = r_match;

endmodule

// File: tb/tb_bloom_filter_table.sv
// Testbench for bloom_filter_table: table-driven lookups checked through an expected-result
// queue, plus hand sequences for clear timing, dropped writes, read-before-write and reset.
// Lookups are driven on the falling edge and the result is sampled one falling edge later.
module tb_bloom_filter_table;

  localparam int HC = 10;
  localparam int HW = 12;
  localparam int HB = HC * HW;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [5:0]    str_len;
  logic [HB-1:0] hash;
  logic [HC-1:0] hash_mask_val;
  logic          wr_data, wr_stb, full_clr_stb;
  logic          ready, full_clr_done;
  logic          lookup_vld_i;
  logic [5:0]    lookup_len_i;
  logic [HB-1:0] lookup_hash_i;
  logic          match_vld_o, match_o;

  bloom_filter_table dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .str_len(str_len), .hash(hash), .hash_mask_val(hash_mask_val),
    .wr_data(wr_data), .wr_stb(wr_stb), .full_clr_stb(full_clr_stb),
    .ready(ready), .full_clr_done(full_clr_done),
    .lookup_vld_i(lookup_vld_i), .lookup_len_i(lookup_len_i), .lookup_hash_i(lookup_hash_i),
    .match_vld_o(match_vld_o), .match_o(match_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic  exp;
    string nm;
  } sb_item_t;

  typedef struct {
    logic [5:0]    len;
    logic [HB-1:0] h;
    logic          exp;
    string         nm;
  } vec_t;

  sb_item_t sb[$];
  vec_t     vecs[10];
  int       checks = 0;
  int       errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [HB-1:0] mk(input int mul, input int add);
    logic [HB-1:0] h;
    h = '0;
    for (int i = 0; i < HC; i++) h[i*HW +: HW] = HW'(i * mul + add);
    return h;
  endfunction

  task automatic wr(input logic [5:0] len, input logic [HB-1:0] h,
                    input logic [HC-1:0] m, input logic d);
    @(negedge clk_i);
    str_len = len; hash = h; hash_mask_val = m; wr_data = d; wr_stb = 1'b1;
    @(negedge clk_i);
    wr_stb = 1'b0;
  endtask

  // Drive one query, queue its expected result, then pop and compare when it emerges.
  task automatic lookup(input logic [5:0] len, input logic [HB-1:0] h,
                        input logic e, input string nm);
    sb_item_t it;
    @(negedge clk_i);
    lookup_vld_i = 1'b1; lookup_len_i = len; lookup_hash_i = h;
    it.exp = e; it.nm = nm;
    sb.push_back(it);
    @(negedge clk_i);
    lookup_vld_i = 1'b0;
    chk({nm, "_vld"}, int'(match_vld_o), 1);
    if (match_vld_o && sb.size() > 0) begin
      it = sb.pop_front();
      chk(it.nm, int'(match_o), int'(it.exp));
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (!ready && cyc < 5000) begin
      @(negedge clk_i);
      cyc++;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    full_clr_stb = 1'b1;
    @(negedge clk_i);
    full_clr_stb = 1'b0;
  endtask

  logic [HB-1:0] h1, h1z, h2, h3, h4, h5;
  int cyc;

  initial begin
    rst_n_i = 1'b0; str_len = '0; hash = '0; hash_mask_val = '0; wr_data = 1'b0;
    wr_stb = 1'b0; full_clr_stb = 1'b0; lookup_vld_i = 1'b0; lookup_len_i = '0;
    lookup_hash_i = '0;
    h1 = mk(12'h111, 0);
    h1z = h1; h1z[3*HW +: HW] = '0;
    h2 = mk(12'h37, 5);
    h3 = mk(-1, 12'hfff);
    h4 = mk(12'h0a3, 12'h321);
    h5 = mk(12'h051, 12'h700);

    vecs[0] = '{6'd8,  h1,  1'b1, "v_hit"};
    vecs[1] = '{6'd8,  h1z, 1'b0, "v_h3_zero"};
    vecs[2] = '{6'd9,  h1,  1'b0, "v_other_bank"};
    vecs[3] = '{6'd33, h1,  1'b0, "v_len33"};
    vecs[4] = '{6'd3,  h1,  1'b0, "v_len3"};
    vecs[5] = '{6'd4,  h1,  1'b0, "v_len4_untouched"};
    vecs[6] = '{6'd4,  h2,  1'b1, "v_len4_hit"};
    vecs[7] = '{6'd5,  h2,  1'b0, "v_len5_isolated"};
    vecs[8] = '{6'd32, h3,  1'b1, "v_len32_hit"};
    vecs[9] = '{6'd31, h3,  1'b0, "v_len31_isolated"};

    // Reset values and the automatic post-reset clear.
    repeat (3) @(negedge clk_i);
    chk("rst_ready", int'(ready), 0);
    chk("rst_done", int'(full_clr_done), 0);
    chk("rst_match_vld", int'(match_vld_o), 0);
    chk("rst_match", int'(match_o), 0);
    rst_n_i = 1'b1;
    wait_ready(cyc);
    chk("init_clear_cycles", cyc, 4096);
    chk("init_done", int'(full_clr_done), 1);
    lookup(6'd8, '0, 1'b0, "init_empty");

    // Basic write, partial-mask rewrite, out-of-range and per-bank isolation.
    wr(6'd8, h1, '1, 1'b1);
    lookup(6'd8, h1, 1'b1, "wr_hit");
    lookup(6'd8, h1z, 1'b0, "h3_zero_miss");
    wr(6'd8, h1, 10'h001, 1'b0);
    lookup(6'd8, h1, 1'b0, "mask_clear_bit");
    wr(6'd8, h1, 10'h001, 1'b1);
    lookup(6'd8, h1, 1'b1, "mask_set_bit");
    wr(6'd3, h1, '1, 1'b1);
    wr(6'd33, h1, '1, 1'b1);
    wr(6'd4, h2, '1, 1'b1);
    wr(6'd32, h3, '1, 1'b1);
    for (int k = 0; k < 10; k++) lookup(vecs[k].len, vecs[k].h, vecs[k].exp, vecs[k].nm);

    // Back-to-back writes, then same-cycle lookup + write returns the old value.
    @(negedge clk_i);
    str_len = 6'd9; hash = h4; hash_mask_val = '1; wr_data = 1'b1; wr_stb = 1'b1;
    @(negedge clk_i);
    str_len = 6'd10; hash = h4;
    @(negedge clk_i);
    wr_stb = 1'b0;
    lookup(6'd10, h4, 1'b1, "b2b_second");
    @(negedge clk_i);
    str_len = 6'd12; hash = h4; hash_mask_val = '1; wr_data = 1'b1; wr_stb = 1'b1;
    lookup_vld_i = 1'b1; lookup_len_i = 6'd12; lookup_hash_i = h4;
    sb.push_back('{1'b0, "rbw_old"});
    @(negedge clk_i);
    wr_stb = 1'b0; lookup_vld_i = 1'b0;
    chk("rbw_vld", int'(match_vld_o), 1);
    if (sb.size() > 0) chk(sb[0].nm, int'(match_o), int'(sb[0].exp));
    if (sb.size() > 0) void'(sb.pop_front());
    lookup(6'd12, h4, 1'b1, "rbw_new");

    // Full clear from IDLE: status falls on the next edge, returns 4096 cycles later.
    pulse_clear();
    chk("clr_ready_fall", int'(ready), 0);
    chk("clr_done_fall", int'(full_clr_done), 0);
    wait_ready(cyc);
    chk("clr_cycles", cyc, 4096);
    chk("clr_done_rise", int'(full_clr_done), 1);
    for (int k = 0; k < 10; k++) lookup(vecs[k].len, vecs[k].h, 1'b0, {vecs[k].nm, "_cleared"});
    lookup(6'd12, h4, 1'b0, "rbw_cleared");

    // Write coincident with clear, lookup and write during CLEAR, restart mid-sweep.
    wr(6'd8, h1, '1, 1'b1);
    lookup(6'd8, h1, 1'b1, "rewrite_hit");
    @(negedge clk_i);
    str_len = 6'd10; hash = h5; hash_mask_val = '1; wr_data = 1'b1; wr_stb = 1'b1;
    full_clr_stb = 1'b1;
    @(negedge clk_i);
    wr_stb = 1'b0; full_clr_stb = 1'b0;
    lookup(6'd8, h1, 1'b0, "lookup_in_clear");
    wr(6'd11, h5, '1, 1'b1);
    repeat (100) @(negedge clk_i);
    pulse_clear();
    wait_ready(cyc);
    chk("restart_cycles", cyc, 4096);
    lookup(6'd10, h5, 1'b0, "coincident_dropped");
    lookup(6'd11, h5, 1'b0, "clear_wr_dropped");
    lookup(6'd8, h1, 1'b0, "restart_cleared");

    // Reset asserted with a result pending: outputs drop at once, clear reruns.
    wr(6'd8, h1, '1, 1'b1);
    @(negedge clk_i);
    lookup_vld_i = 1'b1; lookup_len_i = 6'd8; lookup_hash_i = h1;
    @(posedge clk_i);
    #1;
    lookup_vld_i = 1'b0;
    chk("pre_rst_match", int'(match_o), 1);
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_ready", int'(ready), 0);
    chk("mid_rst_done", int'(full_clr_done), 0);
    chk("mid_rst_match_vld", int'(match_vld_o), 0);
    chk("mid_rst_match", int'(match_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    wait_ready(cyc);
    chk("post_rst_cycles", cyc, 4096);
    lookup(6'd8, h1, 1'b0, "post_rst_cleared");

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
